// File: rtl/cache_tag_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cache_tag_ctrl
// Description : Tag/valid/replacement controller for an N-way set-associative
//               cache with LRU or round-robin victim choice and a set-serial
//               flush sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module cache_tag_ctrl #(
    parameter int WAYS       = 4,
    parameter int TOTAL_SIZE = 16,
    parameter int RAM_DEPTH  = 256,
    parameter int REPL_MODE  = 0
) (
    input  logic                                                 clk,
    input  logic                                                 rst,
    input  logic                                                 req_valid,
    output logic                                                 req_ready,
    input  logic [$clog2(RAM_DEPTH)-1:0]                         req_addr,
    input  logic                                                 req_alloc,
    input  logic                                                 flush_start,
    output logic                                                 flush_busy,
    output logic                                                 resp_valid,
    output logic                                                 resp_hit,
    output logic [$clog2(WAYS)-1:0]                              resp_way,
    output logic                                                 resp_evict_valid,
    output logic [$clog2(RAM_DEPTH)-$clog2(TOTAL_SIZE/WAYS)-1:0] resp_evict_tag
);

    localparam int SETS   = TOTAL_SIZE / WAYS;
    localparam int ADDR_W = $clog2(RAM_DEPTH);
    localparam int SET_W  = $clog2(SETS);
    localparam int TAG_W  = ADDR_W - SET_W;
    localparam int WAY_W  = $clog2(WAYS);

    localparam logic [0:0] c_st_idle  = 1'b0;
    localparam logic [0:0] c_st_flush = 1'b1;

    // Storage
    logic [TAG_W-1:0] r_tag   [SETS][WAYS];
    logic [WAYS-1:0]  r_valid [SETS];
    logic [WAY_W-1:0] r_age   [SETS][WAYS];
    logic [WAY_W-1:0] r_rr    [SETS];

    logic [0:0]       r_state;
    logic [0:0]       w_state_nxt;
    logic [SET_W-1:0] r_flush_cnt;
    logic [SET_W-1:0] w_flush_cnt_nxt;

    logic             r_resp_valid;
    logic             r_resp_hit;
    logic [WAY_W-1:0] r_resp_way;
    logic             r_resp_evict_valid;
    logic [TAG_W-1:0] r_resp_evict_tag;

    logic [SET_W-1:0] w_set;
    logic [TAG_W-1:0] w_tag;
    logic             w_accept;
    logic             w_hit;
    logic [WAY_W-1:0] w_hit_way;
    logic             w_inv_found;
    logic [WAY_W-1:0] w_inv_way;
    logic [WAY_W-1:0] w_lru_way;
    logic [WAY_W-1:0] w_victim;
    logic [WAY_W-1:0] w_way;
    logic             w_alloc;
    logic             w_touch;
    logic [WAY_W-1:0] w_touch_age;
    logic             w_victim_valid;
    logic             w_rr_adv;
    logic             w_flush_last;

    assign w_set    = req_addr[SET_W-1:0];
    assign w_tag    = req_addr[ADDR_W-1:SET_W];
    assign w_accept = req_valid && req_ready;

    // ------------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_st_idle;
            r_flush_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_flush_cnt <= w_flush_cnt_nxt;
        end
    end

    assign w_flush_last = (r_flush_cnt == SET_W'(SETS - 1));

    always_comb begin
        w_state_nxt     = r_state;
        w_flush_cnt_nxt = r_flush_cnt;
        req_ready       = 1'b0;
        flush_busy      = 1'b0;
        case (r_state)
            c_st_idle: begin
                req_ready = !flush_start && !rst;
                if (flush_start) begin
                    w_state_nxt     = c_st_flush;
                    w_flush_cnt_nxt = '0;
                end
            end
            c_st_flush: begin
                flush_busy      = !rst;
                w_flush_cnt_nxt = r_flush_cnt + SET_W'(1);
                if (w_flush_last) begin
                    w_state_nxt = c_st_idle;
                end
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Lookup and victim selection on the current array contents
    // ------------------------------------------------------------------------
    always_comb begin
        w_hit     = 1'b0;
        w_hit_way = '0;
        // Ascending scan: the highest matching index wins on multiple hits
        for (int i = 0; i < WAYS; i++) begin
            if (r_valid[w_set][i] && (r_tag[w_set][i] == w_tag)) begin
                w_hit     = 1'b1;
                w_hit_way = WAY_W'(i);
            end
        end

        w_inv_found = 1'b0;
        w_inv_way   = '0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (!r_valid[w_set][i]) begin
                w_inv_found = 1'b1;
                w_inv_way   = WAY_W'(i);
            end
        end

        w_lru_way = '0;
        for (int i = 0; i < WAYS; i++) begin
            if (r_age[w_set][i] == WAY_W'(WAYS - 1)) begin
                w_lru_way = WAY_W'(i);
            end
        end

        if (w_inv_found) begin
            w_victim = w_inv_way;
        end else if (REPL_MODE == 1) begin
            w_victim = r_rr[w_set];
        end else begin
            w_victim = w_lru_way;
        end

        w_way          = w_hit ? w_hit_way : w_victim;
        w_alloc        = w_accept && !w_hit && req_alloc;
        w_touch        = w_accept && (w_hit || w_alloc);
        w_touch_age    = r_age[w_set][w_way];
        w_victim_valid = r_valid[w_set][w_victim];
        w_rr_adv       = (REPL_MODE == 1) && w_alloc && w_victim_valid;
    end

    // ------------------------------------------------------------------------
    // Valid bits and replacement state
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++) begin
                r_valid[s] <= '0;
                r_rr[s]    <= '0;
                for (int i = 0; i < WAYS; i++) begin
                    r_age[s][i] <= WAY_W'(WAYS - 1 - i);
                end
            end
        end else if (r_state == c_st_flush) begin
            r_valid[r_flush_cnt] <= '0;
            if (w_flush_last) begin
                for (int s = 0; s < SETS; s++) begin
                    r_rr[s] <= '0;
                    for (int i = 0; i < WAYS; i++) begin
                        r_age[s][i] <= WAY_W'(WAYS - 1 - i);
                    end
                end
            end
        end else begin
            if (w_alloc) begin
                r_valid[w_set][w_victim] <= 1'b1;
            end
            if (w_rr_adv) begin
                r_rr[w_set] <= r_rr[w_set] + WAY_W'(1);
            end
            // Touched way becomes MRU; only younger ways age
            if (w_touch) begin
                for (int i = 0; i < WAYS; i++) begin
                    if (WAY_W'(i) == w_way) begin
                        r_age[w_set][i] <= '0;
                    end else if (r_age[w_set][i] < w_touch_age) begin
                        r_age[w_set][i] <= r_age[w_set][i] + WAY_W'(1);
                    end
                end
            end
        end
    end

    // Tag contents are qualified by the valid bits and need no reset
    always_ff @(posedge clk) begin
        if (w_alloc) begin
            r_tag[w_set][w_victim] <= w_tag;
        end
    end

    // ------------------------------------------------------------------------
    // Registered response
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_resp_valid       <= 1'b0;
            r_resp_hit         <= 1'b0;
            r_resp_way         <= '0;
            r_resp_evict_valid <= 1'b0;
            r_resp_evict_tag   <= '0;
        end else begin
            r_resp_valid <= w_accept;
            if (w_accept) begin
                r_resp_hit         <= w_hit;
                r_resp_way         <= w_way;
                r_resp_evict_valid <= w_alloc && w_victim_valid;
                r_resp_evict_tag   <= (w_alloc && w_victim_valid) ? r_tag[w_set][w_victim] : '0;
            end
        end
    end

    assign resp_valid       = r_resp_valid;
    assign resp_hit         = r_resp_hit;
    assign resp_way         = r_resp_way;
    assign resp_evict_valid = r_resp_evict_valid;
    assign resp_evict_tag   = r_resp_evict_tag;

endmodule
`default_nettype wire

// File: tb/tb_cache_tag_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_cache_tag_ctrl
// Description : Directed, table-driven bench for cache_tag_ctrl in LRU and
//               round-robin modes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_tag_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic       req_alloc;
    logic       flush_start;
    logic [7:0] req_addr;

    logic       d0_ready, d0_busy, d0_rv, d0_hit, d0_ev;
    logic [1:0] d0_way;
    logic [5:0] d0_evtag;
    logic       d1_ready, d1_busy, d1_rv, d1_hit, d1_ev;
    logic [1:0] d1_way;
    logic [5:0] d1_evtag;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    cache_tag_ctrl #(.WAYS(4), .TOTAL_SIZE(16), .RAM_DEPTH(256), .REPL_MODE(0)) u_dut_lru (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(d0_ready),
        .req_addr(req_addr), .req_alloc(req_alloc), .flush_start(flush_start),
        .flush_busy(d0_busy), .resp_valid(d0_rv), .resp_hit(d0_hit), .resp_way(d0_way),
        .resp_evict_valid(d0_ev), .resp_evict_tag(d0_evtag)
    );

    cache_tag_ctrl #(.WAYS(4), .TOTAL_SIZE(16), .RAM_DEPTH(256), .REPL_MODE(1)) u_dut_rr (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(d1_ready),
        .req_addr(req_addr), .req_alloc(req_alloc), .flush_start(flush_start),
        .flush_busy(d1_busy), .resp_valid(d1_rv), .resp_hit(d1_hit), .resp_way(d1_way),
        .resp_evict_valid(d1_ev), .resp_evict_tag(d1_evtag)
    );

    typedef struct {
        logic [7:0] addr;
        logic       alloc;
        logic       sel;     // 0: LRU instance, 1: round-robin instance
        logic       hit;
        logic [1:0] way;
        logic       ev;
        logic [5:0] evtag;
    } vec_t;

    vec_t vecs [27];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic run_vecs(input int lo, input int hi);
        for (int k = lo; k <= hi; k++) begin
            @(negedge clk);
            req_valid = 1'b1;
            req_addr  = vecs[k].addr;
            req_alloc = vecs[k].alloc;
            #1;
            chk($sformatf("v%0d ready", k), vecs[k].sel ? d1_ready : d0_ready, 1);
            @(posedge clk);
            #1;
            if (vecs[k].sel) begin
                chk($sformatf("v%0d resp_valid", k), d1_rv, 1);
                chk($sformatf("v%0d hit", k), d1_hit, vecs[k].hit);
                chk($sformatf("v%0d way", k), d1_way, vecs[k].way);
                chk($sformatf("v%0d evict_valid", k), d1_ev, vecs[k].ev);
                chk($sformatf("v%0d evict_tag", k), d1_evtag, vecs[k].evtag);
            end else begin
                chk($sformatf("v%0d resp_valid", k), d0_rv, 1);
                chk($sformatf("v%0d hit", k), d0_hit, vecs[k].hit);
                chk($sformatf("v%0d way", k), d0_way, vecs[k].way);
                chk($sformatf("v%0d evict_valid", k), d0_ev, vecs[k].ev);
                chk($sformatf("v%0d evict_tag", k), d0_evtag, vecs[k].evtag);
            end
        end
        @(negedge clk);
        req_valid = 1'b0;
        req_alloc = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst         = 1'b1;
        req_valid   = 1'b0;
        flush_start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int busy_cnt;
        //            addr   al    sel   hit   way   ev    evtag
        vecs[0]  = '{8'h10, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 6'h00};
        vecs[1]  = '{8'h10, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 6'h00};
        vecs[2]  = '{8'h00, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 6'h00};
        vecs[3]  = '{8'h04, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0, 6'h00};
        vecs[4]  = '{8'h08, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 6'h00};
        vecs[5]  = '{8'h0C, 1'b1, 1'b0, 1'b0, 2'd3, 1'b0, 6'h00};
        vecs[6]  = '{8'h00, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 6'h00};
        vecs[7]  = '{8'h10, 1'b1, 1'b0, 1'b0, 2'd1, 1'b1, 6'h01};
        vecs[8]  = '{8'h20, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 6'h00};
        vecs[9]  = '{8'h20, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 6'h00};
        vecs[10] = '{8'h10, 1'b1, 1'b0, 1'b1, 2'd1, 1'b0, 6'h00};
        vecs[11] = '{8'h01, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 6'h00};
        vecs[12] = '{8'h00, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 6'h00};
        vecs[13] = '{8'h10, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 6'h00};
        vecs[14] = '{8'h00, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 6'h00};
        vecs[15] = '{8'h04, 1'b1, 1'b1, 1'b0, 2'd1, 1'b0, 6'h00};
        vecs[16] = '{8'h08, 1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 6'h00};
        vecs[17] = '{8'h0C, 1'b1, 1'b1, 1'b0, 2'd3, 1'b0, 6'h00};
        vecs[18] = '{8'h04, 1'b0, 1'b1, 1'b1, 2'd1, 1'b0, 6'h00};
        vecs[19] = '{8'h10, 1'b1, 1'b1, 1'b0, 2'd0, 1'b1, 6'h00};
        vecs[20] = '{8'h14, 1'b1, 1'b1, 1'b0, 2'd1, 1'b1, 6'h01};
        vecs[21] = '{8'h18, 1'b1, 1'b1, 1'b0, 2'd2, 1'b1, 6'h02};
        vecs[22] = '{8'h1C, 1'b1, 1'b1, 1'b0, 2'd3, 1'b1, 6'h03};
        vecs[23] = '{8'h20, 1'b1, 1'b1, 1'b0, 2'd0, 1'b1, 6'h04};
        vecs[24] = '{8'h14, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 6'h00};
        vecs[25] = '{8'h20, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 6'h00};
        vecs[26] = '{8'h10, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 6'h00};

        rst         = 1'b1;
        req_valid   = 1'b0;
        req_alloc   = 1'b0;
        req_addr    = 8'h00;
        flush_start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset resp_valid", d0_rv, 0);
        chk("reset flush_busy", d0_busy, 0);
        chk("reset req_ready", d0_ready, 1);
        chk("reset rr req_ready", d1_ready, 1);

        // Allocate-then-hit
        run_vecs(0, 1);

        // LRU fill, touch, evict, non-allocating misses
        do_reset();
        run_vecs(2, 11);

        // Flush raised together with a request
        @(negedge clk);
        flush_start = 1'b1;
        req_valid   = 1'b1;
        req_addr    = 8'h00;
        req_alloc   = 1'b1;
        #1;
        chk("flush req_ready", d0_ready, 0);
        busy_cnt = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #1;
            if (d0_busy) begin
                busy_cnt++;
                chk($sformatf("flush c%0d req_ready", c), d0_ready, 0);
            end
            chk($sformatf("flush c%0d resp_valid", c), d0_rv, 0);
            @(negedge clk);
            flush_start = 1'b0;
            req_valid   = 1'b0;
            req_alloc   = 1'b0;
        end
        chk("flush busy cycles", busy_cnt, 4);
        chk("post flush req_ready", d0_ready, 1);
        run_vecs(12, 13);

        // Round-robin replacement order
        run_vecs(14, 23);

        // Response from the request accepted just before a flush
        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = 8'h14;
        req_alloc = 1'b0;
        @(negedge clk);
        req_valid   = 1'b0;
        flush_start = 1'b1;
        chk("pre-flush resp_valid", d1_rv, 1);
        chk("pre-flush hit", d1_hit, 1);
        chk("pre-flush way", d1_way, 1);
        @(posedge clk);
        #1;
        chk("flush start busy", d1_busy, 1);
        @(negedge clk);
        flush_start = 1'b0;
        @(posedge clk);
        #1;
        chk("flush cycle2 busy", d1_busy, 1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid-flush reset busy", d1_busy, 0);
        chk("mid-flush reset ready", d1_ready, 1);
        chk("mid-flush reset lru busy", d0_busy, 0);
        run_vecs(24, 26);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
